spi_target: RTL and testbench

- SPI target (responder) for the soc_core SPI masters (SSn/SCLK/MSO/MSI), fixed mode 0 (CPOL=0, CPHA=0), byte-oriented, full duplex.
- Oversamples the SPI pins in the wb_clk_i domain through synchronizers.
- Presents received bytes and accepts transmit bytes through valid/ready handshakes to user logic.
- Used for loopback verification of the SPI pads and as a host-side command port into the user area.

---
 rtl/spi_target_pkg.sv | 31 +++
 rtl/spi_target_sync.sv | 23 ++
 rtl/spi_target.sv | 145 ++++++++++++++
 tb/tb_spi_target.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types, widths and bit-order helpers for the SPI target
package spi_target_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Shift one received bit into the assembly register in wire order
    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] s,
                                                   input logic              b,
                                                   input logic              msb_first);
        return msb_first ? {s[BYTE_W-2:0], b} : {b, s[BYTE_W-1:1]};
    endfunction

    // Drop the bit just sent so the next one sits at the output end
    function automatic logic [BYTE_W-1:0] shift_out(input logic [BYTE_W-1:0] s,
                                                    input logic              msb_first);
        return msb_first ? {s[BYTE_W-2:0], 1'b0} : {1'b0, s[BYTE_W-1:1]};
    endfunction

    // Bit currently presented on the wire
    function automatic logic head_bit(input logic [BYTE_W-1:0] s,
                                      input logic              msb_first);
        return msb_first ? s[BYTE_W-1] : s[0];
    endfunction

endpackage

// File: rtl/spi_target_sync.sv
// rtl/spi_target_sync.sv - multi-bit flop-chain synchronizer for the asynchronous SPI pins
module spi_target_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Unreset on purpose: a pin level held across reset must not appear as an edge afterwards
    always_ff @(posedge clk_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - mode-0 byte-oriented SPI target with valid/ready rx and tx handshakes
module spi_target
    import spi_target_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_BYTE   = 8'hFF,
    parameter bit                MSB_FIRST   = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sclk_i,
    input  logic              ssn_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oeb_o,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              busy
);

    logic [2:0] pins_s;
    logic       sclk_s, ssn_s, mosi_s;
    logic       sclk_prev_q, ssn_prev_q;
    logic       sclk_rise, sclk_fall, ssn_fall, ssn_rise;

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]      tx_shift_q, tx_shift_d;
    logic [BYTE_W-1:0]      rx_shift_q, rx_shift_d;
    logic [BYTE_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   load_tx;
    logic                   tx_take, overrun;

    spi_target_sync #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (wb_clk_i),
        .d_i   ({sclk_i, ssn_i, mosi_i}),
        .q_o   (pins_s)
    );

    assign {sclk_s, ssn_s, mosi_s} = pins_s;

    // Previous synced sample, paired with the current one for edge detection
    always_ff @(posedge wb_clk_i) begin
        sclk_prev_q <= sclk_s;
        ssn_prev_q  <= ssn_s;
    end

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ssn_fall  = ~ssn_s & ssn_prev_q;
    assign ssn_rise  = ssn_s & ~ssn_prev_q;

    // State and datapath registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Next-state: select loads a tx byte, rises sample mosi, falls advance or reload miso, deselect aborts
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ready;
        load_tx    = 1'b0;
        tx_take    = 1'b0;
        overrun    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ssn_fall) begin
                    load_tx   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // A byte completing in the same cycle as deselect still lands before the abort
                if (sclk_rise) begin
                    rx_shift_d = shift_in(rx_shift_q, mosi_s, MSB_FIRST);
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = rx_shift_d;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun = 1'b1;
                        end
                    end
                end
                if (ssn_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = shift_out(tx_shift_q, MSB_FIRST);
                    end else begin
                        load_tx = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_tx) begin
            if (tx_valid) begin
                tx_shift_d = tx_data;
                tx_take    = 1'b1;
            end else begin
                tx_shift_d = IDLE_BYTE;
            end
        end
    end

    assign tx_ready   = tx_take & ~wb_rst_i;
    assign rx_overrun = overrun & ~wb_rst_i;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = (state_q == SHIFT);
    assign miso_oeb_o = (state_q != SHIFT);
    assign miso_o     = (state_q == SHIFT) ? head_bit(tx_shift_q, MSB_FIRST) : 1'b0;

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - scoreboard bench for spi_target driving a mode-0 SPI master model
module tb_spi_target;

    localparam int SYNC = 2;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, ssn = 1'b1, mosi = 1'b0;
    logic       miso_o, miso_oeb_o;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       rx_overrun;
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_q[$];
    int         tx_pulses = 0;
    int         ovr_pulses = 0;
    int         ovr_exp = 0;
    bit         rx_pending = 0;

    always #5 clk = ~clk;

    spi_target #(
        .SYNC_STAGES (SYNC),
        .IDLE_BYTE   (8'hFF),
        .MSB_FIRST   (1'b1)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .sclk_i     (sclk),
        .ssn_i      (ssn),
        .mosi_i     (mosi),
        .miso_o     (miso_o),
        .miso_oeb_o (miso_oeb_o),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_overrun (rx_overrun),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference rx model: a byte lands unless one is already pending and nobody is reading
    task automatic model_rx(input logic [7:0] b);
        if (rx_ready) rx_exp.push_back(b);
        else if (!rx_pending) begin
            rx_exp.push_back(b);
            rx_pending = 1;
        end else ovr_exp++;
    endtask

    // tx producer: offers the head of tx_q, pops it once a tx_ready cycle has been seen
    initial begin
        bit take;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            take = tx_ready && tx_valid;
            @(posedge clk);
            #1;
            if (take && tx_q.size() != 0) void'(tx_q.pop_front());
            tx_valid = (tx_q.size() != 0);
            tx_data  = tx_valid ? tx_q[0] : 8'h00;
        end
    end

    // Monitor: compares every consumed rx byte against the scoreboard, counts pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_ready) begin
                tx_pulses++;
                check("tx_ready_with_valid", 32'(tx_valid), 32'd1);
            end
            if (rx_overrun) ovr_pulses++;
            if (rx_valid && rx_ready) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
                end
            end
        end
    end

    task automatic xfer(input string tag, input logic [7:0] mo[4], input int n, input logic [7:0] mi[4]);
        logic [7:0] got;
        ssn = 1'b0;
        repeat (8) @(negedge clk);
        check({tag, "_oeb_selected"}, 32'(miso_oeb_o), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int b = 0; b < n; b++) begin
            model_rx(mo[b]);
            got = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                mosi = mo[b][i];
                repeat (HALF) @(negedge clk);
                got  = {got[6:0], miso_o};
                sclk = 1'b1;
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
            end
            check({tag, "_miso"}, 32'(got), 32'(mi[b]));
        end
        repeat (HALF) @(negedge clk);
        ssn  = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
        check({tag, "_oeb_released"}, 32'(miso_oeb_o), 32'd1);
    endtask

    // One transfer: the expected MISO stream is the supplied tx bytes in order, then IDLE_BYTE
    task automatic run_case(input string tag, input logic [7:0] mo[4], input int n,
                            input logic [7:0] tl[4], input int tn);
        logic [7:0] mi[4];
        int p0;
        int w;
        for (int i = 0; i < tn; i++) tx_q.push_back(tl[i]);
        for (int i = 0; i < 4; i++) mi[i] = (i < tn) ? tl[i] : 8'hFF;
        p0 = tx_pulses;
        repeat (3) @(negedge clk);
        xfer(tag, mo, n, mi);
        if (rx_ready) begin
            for (w = 0; w < 100 && rx_exp.size() != 0; w++) @(negedge clk);
            check({tag, "_rx_drained"}, 32'(rx_exp.size()), 32'd0);
        end
        check({tag, "_tx_ready_pulses"}, 32'(tx_pulses - p0), 32'(tn));
    endtask

    initial begin
        logic [7:0] mo[4];
        logic [7:0] tl[4];
        int p0, o0, lat, n, tn;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_miso", 32'(miso_o), 32'd0);
        check("rst_oeb", 32'(miso_oeb_o), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        run_case("basic", '{8'h3C, 8'h00, 8'h00, 8'h00}, 1, '{8'hA5, 8'h00, 8'h00, 8'h00}, 1);
        run_case("burst", '{8'hC1, 8'hC2, 8'hC3, 8'h00}, 3, '{8'h11, 8'h22, 8'h33, 8'h00}, 3);
        run_case("no_tx", '{8'h00, 8'h00, 8'h00, 8'h00}, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0);

        // Overrun: nobody reads, second byte must be dropped
        rx_ready = 1'b0;
        o0 = ovr_pulses;
        run_case("ovr", '{8'h5A, 8'hC3, 8'h00, 8'h00}, 2, '{8'h00, 8'h00, 8'h00, 8'h00}, 0);
        check("ovr_rx_data_kept", 32'(rx_data), 32'h5A);
        check("ovr_rx_valid", 32'(rx_valid), 32'd1);
        check("ovr_pulses", 32'(ovr_pulses - o0), 32'd1);
        rx_ready   = 1'b1;
        rx_pending = 0;
        repeat (4) @(negedge clk);
        check("ovr_rx_drained", 32'(rx_exp.size()), 32'd0);

        // Abort after five SCLK edges; the consumed tx byte must not reappear afterwards
        tx_q.push_back(8'h99);
        p0 = tx_pulses;
        repeat (3) @(negedge clk);
        ssn = 1'b0;
        repeat (8) @(negedge clk);
        for (int e = 0; e < 5; e++) begin
            if (e % 2 == 0) begin
                mosi = 1'($urandom);
                repeat (HALF) @(negedge clk);
                sclk = 1'b1;
            end else begin
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
            end
        end
        repeat (HALF) @(negedge clk);
        ssn = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!miso_oeb_o && lat < 10);
        check("abort_oeb_latency_ok", 32'(lat <= SYNC + 2), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        sclk = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_rx_valid", 32'(rx_valid), 32'd0);
        check("abort_tx_pulses", 32'(tx_pulses - p0), 32'd1);
        run_case("after_abort", '{8'h81, 8'h00, 8'h00, 8'h00}, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0);

        // Reset pulse during bit 3
        ssn = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            mosi = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_miso", 32'(miso_o), 32'd0);
        check("mid_rst_oeb", 32'(miso_oeb_o), 32'd1);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd0);
        check("mid_rst_rx_data", 32'(rx_data), 32'd0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_rx_overrun", 32'(rx_overrun), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (HALF) @(negedge clk);
        check("mid_rst_no_restart", 32'(busy), 32'd0);
        ssn = 1'b1;
        repeat (12) @(negedge clk);
        run_case("after_reset", '{8'h7E, 8'h00, 8'h00, 8'h00}, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0);

        // Randomized transfers
        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(1, 3);
            tn = $urandom_range(0, n);
            for (int i = 0; i < 4; i++) begin
                mo[i] = 8'($urandom);
                tl[i] = 8'($urandom);
            end
            run_case("rand", mo, n, tl, tn);
        end

        check("overrun_total", 32'(ovr_pulses), 32'(ovr_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
